// File: rtl/ssd_pkg.sv
// Shared types and constants for the SSD minimum-search block.
package ssd_pkg;

    localparam int SSD_W = 20;
    localparam logic [SSD_W-1:0] SSD_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

endpackage

// File: rtl/ssd_min_search_if.sv
// Candidate stream and result bus of ssd_min_search.
// SSD_MIN_EARLY_EXIT_EN adds the thr_ssd early-exit threshold.
interface ssd_min_search_if #(
    parameter int XW = 3,
    parameter int YW = 3
);
    import ssd_pkg::*;

    logic             start;
    logic [SSD_W-1:0] z;
    logic             z_valid;
`ifdef SSD_MIN_EARLY_EXIT_EN
    logic [SSD_W-1:0] thr_ssd;
`endif
    logic             busy;
    logic             done;
    logic [SSD_W-1:0] best_ssd;
    logic [XW-1:0]    best_x;
    logic [YW-1:0]    best_y;

`ifdef SSD_MIN_EARLY_EXIT_EN
    modport master (output start, z, z_valid, thr_ssd,
                    input  busy, done, best_ssd, best_x, best_y);
    modport slave  (input  start, z, z_valid, thr_ssd,
                    output busy, done, best_ssd, best_x, best_y);
`else
    modport master (output start, z, z_valid,
                    input  busy, done, best_ssd, best_x, best_y);
    modport slave  (input  start, z, z_valid,
                    output busy, done, best_ssd, best_x, best_y);
`endif

endinterface

// File: rtl/ssd_cmp_sel.sv
// Combinational compare-and-select: candidate replaces best only on strict less-than,
// so ties keep the earlier candidate in raster order.
module ssd_cmp_sel
    import ssd_pkg::*;
#(
    parameter int XW = 3,
    parameter int YW = 3
) (
    input  logic [SSD_W-1:0] cur_ssd,
    input  logic [XW-1:0]    cur_x,
    input  logic [YW-1:0]    cur_y,
    input  logic [SSD_W-1:0] cand_ssd,
    input  logic [XW-1:0]    cand_x,
    input  logic [YW-1:0]    cand_y,
    output logic [SSD_W-1:0] next_ssd,
    output logic [XW-1:0]    next_x,
    output logic [YW-1:0]    next_y,
    output logic             upd
);

    assign upd      = (cand_ssd < cur_ssd);
    assign next_ssd = upd ? cand_ssd : cur_ssd;
    assign next_x   = upd ? cand_x   : cur_x;
    assign next_y   = upd ? cand_y   : cur_y;

endmodule

// File: rtl/ssd_min_search.sv
// Tracks raster position of each SSD candidate and reports the window minimum with a done pulse.
// SSD_MIN_EARLY_EXIT_EN: a candidate at or below thr_ssd is taken immediately and ends the window.
module ssd_min_search
    import ssd_pkg::*;
#(
    parameter int SRH_W = 8,
    parameter int SRH_H = 8,
    parameter int XW    = 3,
    parameter int YW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    ssd_min_search_if.slave   bus
);

    state_t           state_reg, state_next;
    logic [XW-1:0]    cx_reg;
    logic [YW-1:0]    cy_reg;
    logic [SSD_W-1:0] best_ssd_reg;
    logic [XW-1:0]    best_x_reg;
    logic [YW-1:0]    best_y_reg;

    logic [SSD_W-1:0] sel_ssd;
    logic [XW-1:0]    sel_x;
    logic [YW-1:0]    sel_y;
    logic             upd;
    logic             accept;
    logic             last_cand;
    logic             hit;
    logic             cx_wrap;

    assign accept    = (state_reg == SEARCH) && bus.z_valid;
    assign cx_wrap   = (cx_reg == XW'(SRH_W - 1));
    assign last_cand = cx_wrap && (cy_reg == YW'(SRH_H - 1));

`ifdef SSD_MIN_EARLY_EXIT_EN
    assign hit = (bus.z <= bus.thr_ssd);
`else
    assign hit = 1'b0;
`endif

    ssd_cmp_sel #(.XW(XW), .YW(YW)) u_cmp_sel (
        .cur_ssd  (best_ssd_reg),
        .cur_x    (best_x_reg),
        .cur_y    (best_y_reg),
        .cand_ssd (bus.z),
        .cand_x   (cx_reg),
        .cand_y   (cy_reg),
        .next_ssd (sel_ssd),
        .next_x   (sel_x),
        .next_y   (sel_y),
        .upd      (upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = SEARCH;
            SEARCH:  if (accept && (last_cand || hit)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_reg       <= '0;
            cy_reg       <= '0;
            best_ssd_reg <= '0;
            best_x_reg   <= '0;
            best_y_reg   <= '0;
        end else if ((state_reg == IDLE) && bus.start) begin
            cx_reg       <= '0;
            cy_reg       <= '0;
            best_ssd_reg <= SSD_MAX;
            best_x_reg   <= '0;
            best_y_reg   <= '0;
        end else if (accept) begin
            // An early-exit hit overrides the compare: the threshold match wins outright.
            if (hit) begin
                best_ssd_reg <= bus.z;
                best_x_reg   <= cx_reg;
                best_y_reg   <= cy_reg;
            end else begin
                best_ssd_reg <= sel_ssd;
                best_x_reg   <= sel_x;
                best_y_reg   <= sel_y;
            end
            if (cx_wrap) begin
                cx_reg <= '0;
                cy_reg <= cy_reg + YW'(1);
            end else begin
                cx_reg <= cx_reg + XW'(1);
            end
        end
    end

    // Status outputs decode the state register directly, so they stay registered.
    assign bus.busy     = (state_reg == SEARCH);
    assign bus.done     = (state_reg == DONE);
    assign bus.best_ssd = best_ssd_reg;
    assign bus.best_x   = best_x_reg;
    assign bus.best_y   = best_y_reg;

    logic unused_upd;
    assign unused_upd = upd;

endmodule
